// File: rtl/dp_arbiter_pkg.sv
// Shared definitions for the dp_arbiter slice: FSM state encoding and defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dp_arbiter_pkg;

    localparam int DP_DATA_W  = 8;   // default operand/result width
    localparam int DP_TIMEOUT = 31;  // default WAIT budget before abort (1..255)
    localparam int CNT_W      = 8;   // timeout counter width; TIMEOUT <= 255 so it never wraps

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

endpackage

// File: rtl/dp_arbiter_rr.sv
// rr_arb2: combinational 2-way round-robin pick between two requesters.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
//   req0, req1 : request lines
//   ptr        : requester that wins when both request
//   sel        : winning requester index (meaningful only when any=1)
//   any        : at least one request present
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic sel,
    output logic any
);

    // A lone request wins outright; a tie is settled by the pointer.
    assign sel = (req0 && req1) ? ptr : req1;
    assign any = req0 || req1;

endmodule

// File: rtl/dp_arbiter.sv
// dp_arbiter: shares one datapath between two requesters, one transaction at a time.
// Latency: ack in cycle 3+D counting the granting IDLE cycle as 1 (D = WAIT cycles).
// Backpressure: requests are held off until the in-flight transaction acks; a
//   datapath that never completes is aborted after TIMEOUT+1 WAIT cycles (err=1).
//   clk, rst          : clock, async active-high reset
//   req0/x0, req1/x1  : requests with operands
//   ack0, ack1        : one-cycle result strobes, res/err valid with them
//   dp_x, dp_w        : operand and start pulse to the datapath
//   dp_done, dp_res   : datapath completion and result
module dp_arbiter
    import dp_arbiter_pkg::*;
#(
    parameter int DATA_W  = DP_DATA_W,
    parameter int TIMEOUT = DP_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] x0,
    input  logic              req1,
    input  logic [DATA_W-1:0] x1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] res,
    output logic              err,
    output logic [DATA_W-1:0] dp_x,
    output logic              dp_w,
    input  logic              dp_done,
    input  logic [DATA_W-1:0] dp_res
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t           state;
    state_t           state_nxt;
    logic             ptr;       // round-robin pointer: requester favoured on a tie
    logic             owner;     // requester of the transaction in flight
    logic [CNT_W-1:0] cnt;       // WAIT cycles elapsed without completion
    logic             abort;     // transaction ended by timeout
    logic             pick;
    logic             pick_any;

    rr_arb2 u_rr (
        .req0 (req0),
        .req1 (req1),
        .ptr  (ptr),
        .sel  (pick),
        .any  (pick_any)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = START;
            START:   state_nxt = WAIT;
            // Completion on the final allowed cycle still counts as success.
            WAIT:    if (dp_done || (cnt == TIMEOUT_CNT)) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 1'b0;
            owner <= 1'b0;
            cnt   <= '0;
            abort <= 1'b0;
            dp_x  <= '0;
            res   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    // Operand is captured once at grant so later changes on
                    // x0/x1 cannot disturb the datapath mid-transaction.
                    if (pick_any) begin
                        owner <= pick;
                        dp_x  <= pick ? x1 : x0;
                        abort <= 1'b0;
                    end
                end
                START: begin
                    cnt <= '0;
                end
                WAIT: begin
                    if (dp_done) begin
                        res <= dp_res;
                    end else if (cnt == TIMEOUT_CNT) begin
                        abort <= 1'b1;
                        res   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    // Hand the tie-break to whoever was not just served.
                    ptr <= ~owner;
                end
                default: ;
            endcase
        end
    end

    // dp_done is only looked at in WAIT, so stray pulses elsewhere are harmless.
    assign dp_w = (state == START);
    assign ack0 = (state == RESP) && !owner;
    assign ack1 = (state == RESP) &&  owner;
    assign err  = (state == RESP) &&  abort;

endmodule

// File: doc/dp_arbiter.md
DP_ARBITER -- requirements
Module: dp_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, width of operand and result buses.
REQ-002 Parameter TIMEOUT, default 31, maximum WAIT cycles before abort; range 1..255.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0  input  1  requester 0 request, held high until ack0.
REQ-006 x0  input  DATA_W  requester 0 operand, valid while req0 high.
REQ-007 req1  input  1  requester 1 request, held high until ack1.
REQ-008 x1  input  DATA_W  requester 1 operand, valid while req1 high.
REQ-009 ack0  output  1  one-cycle pulse: result for requester 0 on res.
REQ-010 ack1  output  1  one-cycle pulse: result for requester 1 on res.
REQ-011 res  output  DATA_W  registered result, valid only in an ack cycle.
REQ-012 err  output  1  one-cycle pulse with ack: transaction aborted by timeout.
REQ-013 dp_x  output  DATA_W  registered operand driven to the shared datapath.
REQ-014 dp_w  output  1  one-cycle start pulse to the datapath control unit.
REQ-015 dp_done  input  1  datapath completion flag.
REQ-016 dp_res  input  DATA_W  datapath result, sampled when dp_done high in WAIT.

Function
REQ-017 FSM states SHALL be IDLE, START, WAIT, RESP; encoding from the shared package.
REQ-018 IDLE: no request -> stay; any request -> pick owner per REQ-022, register x_owner into dp_x, go START.
REQ-019 START: dp_w=1 for exactly this cycle, clear timeout counter, go WAIT.
REQ-020 WAIT: dp_done=1 -> register dp_res into res, go RESP; else counter==TIMEOUT -> set abort flag, res=0, go RESP; else counter+1.
REQ-021 RESP: ackN=1 for owner only, err=abort flag, toggle priority pointer to the other requester, go IDLE.
REQ-022 Arbitration SHALL be 2-way round-robin: single request wins directly; both high -> pointer requester wins; pointer 0 after reset.
REQ-023 Latency SHALL be: ack asserted 3+D cycles after request sampled in IDLE, D = WAIT cycles until dp_done.
REQ-024 dp_done outside WAIT SHALL be ignored; dp_done in the same cycle counter reaches TIMEOUT SHALL count as success.
REQ-025 dp_x SHALL hold stable from START until next IDLE grant; operand changes after grant SHALL not affect it.
REQ-026 Requester dropping req before ack SHALL not abort the transaction; ack still pulses.
REQ-027 ack0 and ack1 SHALL never be high together; at most one transaction in flight.
REQ-028 Requester re-asserting req in the cycle after its ack SHALL compete normally (no back-to-back bias beyond pointer).
REQ-029 Counter width SHALL be 8 bits, no wrap possible since TIMEOUT<=255.

Reset
REQ-030 rst high SHALL immediately force IDLE, pointer=0, counter=0, abort flag=0, dp_x=0, res=0.
REQ-031 During and after reset ack0, ack1, err, dp_w SHALL be 0; reset mid-WAIT discards the transaction with no ack.
REQ-032 First grant possible in the first clock edge after rst deasserts.

Structure
REQ-033 Shared package SHALL hold state encoding constants (IDLE=2'b00, START=2'b01, WAIT=2'b10, RESP=2'b11), DATA_W and TIMEOUT defaults.
REQ-034 One sub-module rr_arb2 SHALL implement the combinational 2-way round-robin pick (req0, req1, ptr -> sel, any).
REQ-035 Remaining FSM, counter and registers SHALL live in dp_arbiter.

Verification
REQ-036 Single req0, x0=8'h05, dp_done after 4 WAIT cycles with dp_res=8'h19 -> dp_w one pulse, dp_x=8'h05, ack0 with res=8'h19 at cycle 7, err=0.
REQ-037 req0 and req1 together from reset (x0=8'h01, x1=8'h02) -> requester 0 served first, then requester 1, dp_x=8'h02 on second dp_w.
REQ-038 Both held continuously for 4 transactions -> ack order 0,1,0,1; never simultaneous acks.
REQ-039 TIMEOUT=3, dp_done never asserted -> ack with err=1 and res=0 exactly 3+3 cycles after grant; next request served normally.
REQ-040 rst pulsed in WAIT, then dp_done pulsed -> no ack, no err; pointer=0; new req1 served with single dp_w pulse.
REQ-041 dp_done high in IDLE and START, req1 dropped after grant -> stray dp_done ignored; ack1 still pulses at completion.
